// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI intersection controller broadcast path.
// Arbiter FSM encoding, broadcast type codes and the CPU count.
package mesi_isc_pkg;

  localparam int CPU_COUNT = 4;

  localparam logic [1:0] BROAD_TYPE_RD = 2'd0;
  localparam logic [1:0] BROAD_TYPE_WR = 2'd1;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_SETTLE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mesi_isc_rr_sel4.sv
// Combinational 4-way round-robin pick: scans upward from last_i+1 (mod 4)
// and reports the first valid index.
module mesi_isc_rr_sel4 (
  input  logic [3:0] valid_i,
  input  logic [1:0] last_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = last_i;
    cand    = last_i;
    // Offset 4 wraps to last_i itself, so the previous winner is tried last.
    for (int i = 1; i <= 4; i++) begin
      cand = last_i + i[1:0];
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_breq_arbiter.sv
// Round-robin arbiter feeding four per-CPU breq FIFO heads into the single
// broadcast FIFO, stamping each accepted entry with a rolling broadcast ID.
//
//  state      | meaning
//  ARB_IDLE   | grant allowed when a head is valid and the FIFO is not full
//  ARB_SETTLE | one-cycle gap so head valids and the full flag catch up
module mesi_isc_breq_arbiter
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    req_valid_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] req_type_array_i,
  input  logic [4*ADDR_WIDTH-1:0]       req_addr_array_i,
  input  logic                          broad_fifo_status_full_i,
  output logic [3:0]                    req_pop_array_o,
  output logic                          broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]         broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o
);

  arb_state_e                  state_q, state_d;
  logic [1:0]                  last_grant_q, last_grant_d;
  logic [BROAD_ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
  logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
  logic [1:0]                  cpu_id_q, cpu_id_d;
  logic                        wr_q, wr_d;
  logic [3:0]                  pop_q, pop_d;

  logic                        sel_found;
  logic [1:0]                  sel_idx;
  logic [ADDR_WIDTH-1:0]       win_addr;
  logic [BROAD_TYPE_WIDTH-1:0] win_type;

  mesi_isc_rr_sel4 u_rr_sel4 (
    .valid_i (req_valid_array_i),
    .last_i  (last_grant_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_comb begin
    win_addr = '0;
    win_type = '0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      if (sel_idx == i[1:0]) begin
        win_addr = req_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_type = req_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_cnt_d     = id_cnt_q;
    id_d         = id_q;
    addr_d       = addr_q;
    type_d       = type_q;
    cpu_id_d     = cpu_id_q;
    wr_d         = 1'b0;
    pop_d        = 4'b0000;
    case (state_q)
      ARB_IDLE: begin
        // Full is only looked at here; SETTLE hides it for one cycle.
        if (sel_found && !broad_fifo_status_full_i) begin
          addr_d       = win_addr;
          type_d       = win_type;
          cpu_id_d     = sel_idx;
          id_d         = id_cnt_q;
          id_cnt_d     = id_cnt_q + BROAD_ID_WIDTH'(1);
          last_grant_d = sel_idx;
          wr_d         = 1'b1;
          pop_d        = 4'b0001 << sel_idx;
          state_d      = ARB_SETTLE;
        end
      end
      ARB_SETTLE: state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 2'd3;
      id_cnt_q     <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      type_q       <= '0;
      cpu_id_q     <= '0;
      wr_q         <= 1'b0;
      pop_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_cnt_q     <= id_cnt_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      cpu_id_q     <= cpu_id_d;
      wr_q         <= wr_d;
      pop_q        <= pop_d;
    end
  end

  assign req_pop_array_o = pop_q;
  assign broad_fifo_wr_o = wr_q;
  assign broad_addr_o    = addr_q;
  assign broad_type_o    = type_q;
  assign broad_cpu_id_o  = cpu_id_q;
  assign broad_id_o      = id_q;

endmodule

// File: tb/tb_mesi_isc_breq_arbiter.sv
// Directed bench for the breq round-robin arbiter: grant order, ID wrap,
// full-flag stall and reset-versus-grant priority.
module tb_mesi_isc_breq_arbiter;

  localparam int AW = 32;
  localparam int TW = 2;
  localparam int IW = 5;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid_array_i;
  logic [4*TW-1:0] req_type_array_i;
  logic [4*AW-1:0] req_addr_array_i;
  logic            broad_fifo_status_full_i;
  logic [3:0]      req_pop_array_o;
  logic            broad_fifo_wr_o;
  logic [AW-1:0]   broad_addr_o;
  logic [TW-1:0]   broad_type_o;
  logic [1:0]      broad_cpu_id_o;
  logic [IW-1:0]   broad_id_o;

  int n_vec;
  int n_miss;

  mesi_isc_breq_arbiter #(
    .ADDR_WIDTH       (AW),
    .BROAD_TYPE_WIDTH (TW),
    .BROAD_ID_WIDTH   (IW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid_array_i        (req_valid_array_i),
    .req_type_array_i         (req_type_array_i),
    .req_addr_array_i         (req_addr_array_i),
    .broad_fifo_status_full_i (broad_fifo_status_full_i),
    .req_pop_array_o          (req_pop_array_o),
    .broad_fifo_wr_o          (broad_fifo_wr_o),
    .broad_addr_o             (broad_addr_o),
    .broad_type_o             (broad_type_o),
    .broad_cpu_id_o           (broad_cpu_id_o),
    .broad_id_o               (broad_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_head(input int cpu, input logic [AW-1:0] addr, input logic [TW-1:0] typ);
    req_addr_array_i[cpu*AW +: AW] = addr;
    req_type_array_i[cpu*TW +: TW] = typ;
  endtask

  // Wait one cycle and expect a grant to the given CPU.
  task automatic expect_grant(input string tag, input int cpu, input int id,
                              input logic [AW-1:0] addr, input logic [TW-1:0] typ);
    @(negedge clk);
    chk({tag, ".wr"},   64'(broad_fifo_wr_o), 64'd1);
    chk({tag, ".pop"},  64'(req_pop_array_o), 64'(4'b0001 << cpu));
    chk({tag, ".cpu"},  64'(broad_cpu_id_o),  64'(cpu));
    chk({tag, ".id"},   64'(broad_id_o),      64'(id));
    chk({tag, ".addr"}, 64'(broad_addr_o),    64'(addr));
    chk({tag, ".type"}, 64'(broad_type_o),    64'(typ));
  endtask

  task automatic expect_quiet(input string tag);
    @(negedge clk);
    chk({tag, ".wr0"},  64'(broad_fifo_wr_o), 64'd0);
    chk({tag, ".pop0"}, 64'(req_pop_array_o), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_array_i = 4'b0000;
    broad_fifo_status_full_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    req_type_array_i = '0;
    req_addr_array_i = '0;
    do_reset();

    // Reset state
    chk("rst.wr",   64'(broad_fifo_wr_o), 64'd0);
    chk("rst.pop",  64'(req_pop_array_o), 64'd0);
    chk("rst.addr", 64'(broad_addr_o),    64'd0);
    chk("rst.type", 64'(broad_type_o),    64'd0);
    chk("rst.cpu",  64'(broad_cpu_id_o),  64'd0);
    chk("rst.id",   64'(broad_id_o),      64'd0);

    // Single request from CPU0
    set_head(0, 32'h0000_1000, 2'd0);
    req_valid_array_i = 4'b0001;
    expect_grant("single", 0, 0, 32'h0000_1000, 2'd0);
    req_valid_array_i = 4'b0000;
    expect_quiet("single.settle");
    chk("single.addr_hold", 64'(broad_addr_o), 64'h1000);
    expect_quiet("single.idle");

    // All four heads valid: 0,1,2,3,0 on every second cycle
    do_reset();
    for (int c = 0; c < 4; c++) set_head(c, 32'h2000 + 32'(c), 2'(c));
    req_valid_array_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_grant($sformatf("rr%0d", g), g % 4, g, 32'h2000 + 32'(g % 4), 2'(g % 4));
      expect_quiet($sformatf("rr%0d.settle", g));
    end
    // last_grant = 0, id counter = 5

    // Full stall with CPU1 and CPU3 pending
    req_valid_array_i = 4'b1010;
    broad_fifo_status_full_i = 1'b1;
    for (int s = 0; s < 10; s++) expect_quiet($sformatf("full%0d", s));
    chk("full.id_hold", 64'(broad_id_o), 64'd4);
    broad_fifo_status_full_i = 1'b0;
    expect_grant("full.rel", 1, 5, 32'h2001, 2'd1);
    req_valid_array_i = 4'b0000;
    expect_quiet("full.settle");

    // 33 back-to-back grants: id 0..31 then 0
    do_reset();
    req_valid_array_i = 4'b1111;
    for (int g = 0; g < 33; g++) begin
      expect_grant($sformatf("wrap%0d", g), g % 4, g % 32, 32'h2000 + 32'(g % 4), 2'(g % 4));
      expect_quiet($sformatf("wrap%0d.settle", g));
    end
    req_valid_array_i = 4'b0000;
    // last_grant = 0, id counter = 1

    // Reset on the same edge as a pending grant
    req_valid_array_i = 4'b0100;
    rst = 1'b1;
    @(negedge clk);
    chk("rstgnt.wr",  64'(broad_fifo_wr_o), 64'd0);
    chk("rstgnt.pop", 64'(req_pop_array_o), 64'd0);
    chk("rstgnt.id",  64'(broad_id_o),      64'd0);
    rst = 1'b0;
    req_valid_array_i = 4'b0101;
    expect_grant("rstgnt.first", 0, 0, 32'h2000, 2'd0);
    req_valid_array_i = 4'b0000;
    expect_quiet("rstgnt.settle");

    // Pointer wrap: CPU3 wins, then 1001 goes to CPU0
    req_valid_array_i = 4'b1000;
    expect_grant("ptrwrap.cpu3", 3, 1, 32'h2003, 2'd3);
    req_valid_array_i = 4'b1001;
    expect_quiet("ptrwrap.settle");
    expect_grant("ptrwrap.cpu0", 0, 2, 32'h2000, 2'd0);
    req_valid_array_i = 4'b0000;
    expect_quiet("ptrwrap.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
